// File: rtl/quad_step_driver_pkg.sv
// Shared constants and the Gray-code step decoder for the quadrature front end.
package quad_step_driver_pkg;

  // Accepted phase encodings, written as {A,B}
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // UPDN encoding seen by the counter
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int unsigned FILT_LEN_DEF = 4;
  localparam int unsigned WRAP_W_DEF   = 8;

  typedef enum logic [1:0] {
    StepNone,
    StepUp,
    StepDn,
    StepBad
  } step_e;

  // Classify one accepted transition. The up sequence is 00->01->11->10->00.
  function automatic step_e step_decode(input logic [1:0] old_ph, input logic [1:0] new_ph);
    step_e s;
    s = StepNone;
    if (old_ph == new_ph) begin
      s = StepNone;
    end else if ((old_ph ^ new_ph) == 2'b11) begin
      s = StepBad;
    end else begin
      case (old_ph)
        PH_00:   s = (new_ph == PH_01) ? StepUp : StepDn;
        PH_01:   s = (new_ph == PH_11) ? StepUp : StepDn;
        PH_11:   s = (new_ph == PH_10) ? StepUp : StepDn;
        PH_10:   s = (new_ph == PH_00) ? StepUp : StepDn;
        default: s = StepNone;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/quad_step_driver_phase_filter.sv
// Two-flop synchroniser plus stability filter for the A/B phase pair.
// accept_o is a combinational strobe in the cycle the candidate is taken;
// phase_o still shows the previous accepted state during that cycle.
module quad_phase_filter
  import quad_step_driver_pkg::*;
#(
  parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic [1:0] phase_o,
  output logic [1:0] cand_o,
  output logic       accept_o
);

  localparam logic [3:0] CntLast = 4'(FILT_LEN - 1);

  logic [1:0] sync1_q, sync2_q, prev_q, acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;

  // Synchroniser chain, previous-candidate history, counter and accepted state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= PH_00;
      sync2_q <= PH_00;
      prev_q  <= PH_00;
      acc_q   <= PH_00;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {a_i, b_i};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive cycles of an unchanged, differing candidate; accept at the last count
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    accept_o = 1'b0;
    if (sync2_q == acc_q) begin
      cnt_d = '0;
    end else if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      accept_o = 1'b1;
      acc_d    = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  assign phase_o = acc_q;
  assign cand_o  = sync2_q;

endmodule

// File: rtl/quad_step_driver.sv
// Quadrature front end for a 4-bit up/down counter: step pulses,
// preset load, sticky illegal-transition flag and signed wrap accounting.
module quad_step_driver
  import quad_step_driver_pkg::*;
#(
  parameter int unsigned FILT_LEN = FILT_LEN_DEF,
  parameter logic [3:0]  PRESET   = 4'b0000,
  parameter int unsigned WRAP_W   = WRAP_W_DEF
) (
  input  logic                     CLK,
  input  logic                     MR,
  input  logic                     A,
  input  logic                     B,
  input  logic                     CLR,
  input  logic                     CO,
  output logic                     EN,
  output logic                     UPDN,
  output logic                     LOAD,
  output logic [3:0]               D,
  output logic                     ERR,
  output logic signed [WRAP_W-1:0] WRAPS
);

  localparam logic signed [WRAP_W-1:0] WrapMax = {1'b0, {(WRAP_W-1){1'b1}}};
  localparam logic signed [WRAP_W-1:0] WrapMin = {1'b1, {(WRAP_W-1){1'b0}}};
  localparam logic signed [WRAP_W-1:0] WrapOne = {{(WRAP_W-1){1'b0}}, 1'b1};

  logic [1:0] phase, cand;
  logic       accept;
  step_e      step;

  logic en_q, en_d, updn_q, updn_d, load_q, load_d, err_q, err_d;
  logic pend_q, pend_d, pdir_q, pdir_d;
  logic signed [WRAP_W-1:0] wraps_q, wraps_d;

  quad_phase_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk_i    (CLK),
    .rst_i    (MR),
    .a_i      (A),
    .b_i      (B),
    .phase_o  (phase),
    .cand_o   (cand),
    .accept_o (accept)
  );

  assign step = step_decode(phase, cand);

  // Output and bookkeeping registers
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      en_q    <= 1'b0;
      updn_q  <= DIR_UP;
      load_q  <= 1'b1;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      pdir_q  <= DIR_UP;
      wraps_q <= '0;
    end else begin
      en_q    <= en_d;
      updn_q  <= updn_d;
      load_q  <= load_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      pdir_q  <= pdir_d;
      wraps_q <= wraps_d;
    end
  end

  // Decode accepted transitions, sample CO after each step, CLR overrides everything
  always_comb begin
    en_d    = 1'b0;
    updn_d  = updn_q;
    load_d  = 1'b1;
    err_d   = err_q;
    wraps_d = wraps_q;
    // The counter updates CO on the edge that consumes EN, so look one cycle later
    pend_d  = en_q;
    pdir_d  = en_q ? updn_q : pdir_q;

    if (accept) begin
      case (step)
        StepUp: begin
          en_d   = 1'b1;
          updn_d = DIR_UP;
        end
        StepDn: begin
          en_d   = 1'b1;
          updn_d = DIR_DN;
        end
        StepBad: err_d = 1'b1;
        default: ;
      endcase
    end

    // CO is level-held, so it is only meaningful on the sample cycle
    if (pend_q && CO) begin
      if (pdir_q == DIR_UP) begin
        if (wraps_q != WrapMax) wraps_d = wraps_q + WrapOne;
      end else begin
        if (wraps_q != WrapMin) wraps_d = wraps_q - WrapOne;
      end
    end

    // A dropped step keeps UPDN; the filter still moves its accepted state
    if (CLR) begin
      en_d    = 1'b0;
      updn_d  = updn_q;
      load_d  = 1'b0;
      err_d   = 1'b0;
      wraps_d = '0;
      pend_d  = 1'b0;
    end
  end

  assign EN    = en_q;
  assign UPDN  = updn_q;
  assign LOAD  = load_q;
  assign D     = PRESET;
  assign ERR   = err_q;
  assign WRAPS = wraps_q;

endmodule
